// File: rtl/prt_dptx_ctl_pkg.sv
// Shared definitions for the DPTX control message path: control bit map,
// message word indices and the source-side frame FSM states.
package prt_dptx_ctl_pkg;

  localparam int P_CTL_WIDTH = 11;

  // Bit positions inside the control word; LANES and BPC are two bits wide
  localparam int CTL_LANES   = 0;
  localparam int CTL_TRN_SEL = 2;
  localparam int CTL_VID0_EN = 3;
  localparam int CTL_VID1_EN = 4;
  localparam int CTL_MST_EN  = 5;
  localparam int CTL_MST_ACT = 6;
  localparam int CTL_SCRM_EN = 7;
  localparam int CTL_TPS4    = 8;
  localparam int CTL_BPC     = 9;

  localparam logic [1:0] MSG_IDX_MSK  = 2'd0;
  localparam logic [1:0] MSG_IDX_CTL  = 2'd1;
  localparam logic [1:0] MSG_IDX_VCTS = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_MSK,
    ST_CTL,
    ST_VCTS
  } msg_state_t;

  // Masked write as applied by the sink to its control register
  function automatic logic [P_CTL_WIDTH-1:0] masked_write(
    input logic [P_CTL_WIDTH-1:0] cur,
    input logic [P_CTL_WIDTH-1:0] msk,
    input logic [P_CTL_WIDTH-1:0] val
  );
    return (cur & ~msk) | (val & msk);
  endfunction

endpackage

// File: rtl/prt_dptx_ctl_msg_mst.sv
// Source end of the DPTX control message path: turns one host command into a
// header/mask/control[/VC time-slot] frame and shadows the sink's control register.
module prt_dptx_ctl_msg_mst
  import prt_dptx_ctl_pkg::*;
#(
  parameter int P_MST     = 0,
  parameter int P_MSG_DAT = 16,
  parameter int P_MSG_ID  = 0
) (
  input  logic                   RST_IN,
  input  logic                   CLK_IN,
  input  logic                   CMD_REQ_IN,
  input  logic [10:0]            CMD_MSK_IN,
  input  logic [10:0]            CMD_CTL_IN,
  input  logic [15:0]            CMD_VC_TS_IN,
  input  logic                   CMD_VC_EN_IN,
  output logic                   CMD_BUSY_OUT,
  output logic                   CMD_ACK_OUT,
  output logic                   CMD_ERR_OUT,
  output logic [10:0]            SHD_CTL_OUT,
  output logic [15:0]            SHD_VC_TS_OUT,
  output logic                   MSG_SOM_OUT,
  output logic                   MSG_EOM_OUT,
  output logic [P_MSG_DAT-1:0]   MSG_DAT_OUT,
  output logic                   MSG_VLD_OUT,
  input  logic                   MSG_RDY_IN
);

  localparam logic [P_MSG_DAT-1:0] HDR_WORD = P_MSG_DAT'(P_MSG_ID);

  msg_state_t             state;
  msg_state_t             state_nxt;
  logic [P_CTL_WIDTH-1:0] msk_q;
  logic [P_CTL_WIDTH-1:0] ctl_q;
  logic [15:0]            vc_ts_q;
  logic                   vc_en_q;
  logic [P_CTL_WIDTH-1:0] shd_ctl_q;
  logic [15:0]            shd_vc_ts_q;
  logic                   err_q;
  logic                   vc_en_eff;
  logic                   xfer;
  logic                   cmd_take;

  assign vc_en_eff = CMD_VC_EN_IN & (P_MST != 0);
  assign cmd_take  = CMD_REQ_IN & (state == ST_IDLE);
  assign xfer      = MSG_VLD_OUT & MSG_RDY_IN;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (CMD_REQ_IN) state_nxt = ST_HDR;
      ST_HDR:  if (xfer) state_nxt = ST_MSK;
      ST_MSK:  if (xfer) state_nxt = ST_CTL;
      ST_CTL:  if (xfer) state_nxt = vc_en_q ? ST_VCTS : ST_IDLE;
      ST_VCTS: if (xfer) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Word outputs depend only on state and captured command, so they hold while stalled
  always_comb begin
    MSG_VLD_OUT = 1'b1;
    MSG_SOM_OUT = 1'b0;
    MSG_EOM_OUT = 1'b0;
    MSG_DAT_OUT = '0;
    case (state)
      ST_HDR: begin
        MSG_SOM_OUT = 1'b1;
        MSG_DAT_OUT = HDR_WORD;
      end
      ST_MSK:  MSG_DAT_OUT = P_MSG_DAT'(msk_q);
      ST_CTL: begin
        MSG_EOM_OUT = ~vc_en_q;
        MSG_DAT_OUT = P_MSG_DAT'(ctl_q);
      end
      ST_VCTS: begin
        MSG_EOM_OUT = 1'b1;
        MSG_DAT_OUT = P_MSG_DAT'(vc_ts_q);
      end
      default: MSG_VLD_OUT = 1'b0;
    endcase
    CMD_BUSY_OUT = MSG_VLD_OUT;
    CMD_ACK_OUT  = MSG_VLD_OUT & MSG_RDY_IN & MSG_EOM_OUT;
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      msk_q   <= '0;
      ctl_q   <= '0;
      vc_ts_q <= '0;
      vc_en_q <= 1'b0;
    end else if (cmd_take) begin
      msk_q   <= CMD_MSK_IN;
      ctl_q   <= CMD_CTL_IN;
      vc_ts_q <= CMD_VC_TS_IN;
      vc_en_q <= vc_en_eff;
    end
  end

  // Shadow follows the sink: it commits only once the whole frame has been accepted
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      shd_ctl_q   <= '0;
      shd_vc_ts_q <= '0;
    end else if (CMD_ACK_OUT) begin
      shd_ctl_q <= masked_write(shd_ctl_q, msk_q, ctl_q);
      if (vc_en_q) shd_vc_ts_q <= vc_ts_q;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) err_q <= 1'b0;
    else        err_q <= CMD_REQ_IN & (state != ST_IDLE);
  end

  assign CMD_ERR_OUT   = err_q;
  assign SHD_CTL_OUT   = shd_ctl_q;
  assign SHD_VC_TS_OUT = (P_MST != 0) ? shd_vc_ts_q : 16'h0000;

endmodule

// File: tb/tb_prt_dptx_ctl_msg_mst.sv
// Scoreboard bench: two instances (P_MST=0 and P_MST=1) share one command and
// ready stream; a negedge monitor checks every transferred word against a frame model.
module tb_prt_dptx_ctl_msg_mst;

  localparam int DW  = 16;
  localparam int ID0 = 'h05A3;
  localparam int ID1 = 'h0012;

  typedef struct packed {
    logic          som;
    logic          eom;
    logic [DW-1:0] dat;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [10:0]   msk = '0;
  logic [10:0]   ctl = '0;
  logic [15:0]   vcts = '0;
  logic          vcen = 1'b0;
  logic          rdy = 1'b0;

  logic          busy [2];
  logic          ack [2];
  logic          err [2];
  logic          som [2];
  logic          eom [2];
  logic          vld [2];
  logic [10:0]   shd_ctl [2];
  logic [15:0]   shd_vc [2];
  logic [DW-1:0] dat [2];

  word_t         exp_q [2][$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            err_seen [2] = '{0, 0};
  int            err_exp = 0;
  logic [10:0]   mdl_ctl [2] = '{11'h0, 11'h0};
  logic [15:0]   mdl_vc [2] = '{16'h0, 16'h0};
  logic          stall_v [2] = '{1'b0, 1'b0};
  word_t         stall_w [2];

  always #5 clk = ~clk;

  prt_dptx_ctl_msg_mst #(.P_MST(0), .P_MSG_DAT(DW), .P_MSG_ID(ID0)) u_dut0 (
    .RST_IN(rst), .CLK_IN(clk), .CMD_REQ_IN(req), .CMD_MSK_IN(msk), .CMD_CTL_IN(ctl),
    .CMD_VC_TS_IN(vcts), .CMD_VC_EN_IN(vcen), .CMD_BUSY_OUT(busy[0]), .CMD_ACK_OUT(ack[0]),
    .CMD_ERR_OUT(err[0]), .SHD_CTL_OUT(shd_ctl[0]), .SHD_VC_TS_OUT(shd_vc[0]),
    .MSG_SOM_OUT(som[0]), .MSG_EOM_OUT(eom[0]), .MSG_DAT_OUT(dat[0]), .MSG_VLD_OUT(vld[0]),
    .MSG_RDY_IN(rdy)
  );

  prt_dptx_ctl_msg_mst #(.P_MST(1), .P_MSG_DAT(DW), .P_MSG_ID(ID1)) u_dut1 (
    .RST_IN(rst), .CLK_IN(clk), .CMD_REQ_IN(req), .CMD_MSK_IN(msk), .CMD_CTL_IN(ctl),
    .CMD_VC_TS_IN(vcts), .CMD_VC_EN_IN(vcen), .CMD_BUSY_OUT(busy[1]), .CMD_ACK_OUT(ack[1]),
    .CMD_ERR_OUT(err[1]), .SHD_CTL_OUT(shd_ctl[1]), .SHD_VC_TS_OUT(shd_vc[1]),
    .MSG_SOM_OUT(som[1]), .MSG_EOM_OUT(eom[1]), .MSG_DAT_OUT(dat[1]), .MSG_VLD_OUT(vld[1]),
    .MSG_RDY_IN(rdy)
  );

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  function automatic logic pickRdy(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 1;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Frame model: header, mask, control, and the VC word only on the MST instance
  task automatic pushFrame(input logic [10:0] m, input logic [10:0] c, input logic [15:0] ts,
                           input logic en);
    for (int k = 0; k < 2; k++) begin
      bit has_vc;
      has_vc = en && (k == 1);
      exp_q[k].push_back({1'b1, 1'b0, (k == 1) ? DW'(ID1) : DW'(ID0)});
      exp_q[k].push_back({1'b0, 1'b0, DW'(m)});
      exp_q[k].push_back({1'b0, !has_vc, DW'(c)});
      if (has_vc) exp_q[k].push_back({1'b0, 1'b1, DW'(ts)});
    end
  endtask

  always @(negedge clk) begin
    word_t cur;
    word_t w;
    logic  exp_ack;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        stall_v[k] = 1'b0;
      end else begin
        cur = {som[k], eom[k], dat[k]};
        if (stall_v[k]) checkOutput("stall_hold", k, {13'h0, vld[k], cur}, {13'h0, 1'b1, stall_w[k]});
        if (vld[k]) checkOutput("busy_with_vld", k, 32'(busy[k]), 32'd1);
        exp_ack = 1'b0;
        if (vld[k] && rdy) begin
          if (exp_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL extra_word dut%0d: got 0x%0h expected no word", k, cur);
          end else begin
            w = exp_q[k].pop_front();
            checkOutput("word", k, 32'(cur), 32'(w));
            exp_ack = w.eom;
          end
        end
        checkOutput("ack", k, 32'(ack[k]), 32'(exp_ack));
        if (err[k]) err_seen[k]++;
        stall_v[k] = vld[k] && !rdy;
        stall_w[k] = cur;
      end
    end
  end

  task automatic applyStimulus(input logic [10:0] m, input logic [10:0] c, input logic [15:0] ts,
                               input logic en, input int mode, input bit collide);
    bit done;
    @(posedge clk); #1;
    req = 1'b1; msk = m; ctl = c; vcts = ts; vcen = en;
    rdy = pickRdy(mode, 0);
    pushFrame(m, c, ts, en);
    @(posedge clk); #1;
    req = 1'b0; msk = 11'($urandom); ctl = 11'($urandom); vcts = 16'($urandom);
    vcen = 1'($urandom);
    rdy = pickRdy(mode, 1);
    done = 1'b0;
    for (int cyc = 2; cyc < 100 && !done; cyc++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (!busy[0] && !busy[1]) begin
        done = 1'b1;
      end else begin
        rdy = pickRdy(mode, cyc);
        if (collide && cyc == 2) begin
          req = 1'b1;
          err_exp++;
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL frame_timeout: busy still set after 100 cycles");
      finishRun();
    end
    for (int k = 0; k < 2; k++) begin
      mdl_ctl[k] = (mdl_ctl[k] & ~m) | (c & m);
      if (en && k == 1) mdl_vc[k] = ts;
      checkOutput("shd_ctl", k, 32'(shd_ctl[k]), 32'(mdl_ctl[k]));
      checkOutput("shd_vc_ts", k, 32'(shd_vc[k]), 32'(mdl_vc[k]));
      checkOutput("queue_drained", k, 32'(exp_q[k].size()), 32'd0);
    end
  endtask

  // Abort a frame while the CTL word is stalled, then confirm a clean restart
  task automatic resetMidFrame();
    @(posedge clk); #1;
    req = 1'b1; msk = 11'h3C3; ctl = 11'h155; vcts = 16'h0102; vcen = 1'b1; rdy = 1'b1;
    pushFrame(11'h3C3, 11'h155, 16'h0102, 1'b1);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_vld", k, 32'(vld[k]), 32'd0);
      checkOutput("rst_busy", k, 32'(busy[k]), 32'd0);
      checkOutput("rst_shd_ctl", k, 32'(shd_ctl[k]), 32'd0);
      checkOutput("rst_shd_vc", k, 32'(shd_vc[k]), 32'd0);
      exp_q[k].delete();
      mdl_ctl[k] = '0;
      mdl_vc[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(11'h7FF, 11'h2A5, 16'h3F3F, 1'b1, 0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_outputs", k,
                  {vld[k], som[k], eom[k], busy[k], ack[k], err[k], 26'h0}, 32'h0);
      checkOutput("reset_dat", k, 32'(dat[k]), 32'd0);
      checkOutput("reset_shd_ctl", k, 32'(shd_ctl[k]), 32'd0);
      checkOutput("reset_shd_vc", k, 32'(shd_vc[k]), 32'd0);
    end
    rst = 1'b0;

    applyStimulus(11'h7FF, 11'h0AB, 16'h0A05, 1'b0, 0, 1'b0);
    applyStimulus(11'h7FF, 11'h0AB, 16'h0A05, 1'b1, 0, 1'b0);
    applyStimulus(11'h0F0, 11'h5A5, 16'h1122, 1'b1, 1, 1'b0);
    applyStimulus(11'h7FF, 11'h0F0, 16'h0000, 1'b0, 0, 1'b0);
    applyStimulus(11'h00F, 11'h7FF, 16'h0000, 1'b0, 1, 1'b0);
    applyStimulus(11'h000, 11'h3AA, 16'h2233, 1'b1, 0, 1'b0);
    applyStimulus(11'h404, 11'h7FF, 16'h0C0D, 1'b1, 0, 1'b1);
    applyStimulus(11'h0C3, 11'h041, 16'h0E0F, 1'b0, 1, 1'b1);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(11'($urandom), 11'($urandom), 16'($urandom), 1'($urandom),
                    2, ($urandom_range(0, 3) == 0));
    end

    resetMidFrame();

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("err_pulses", k, 32'(err_seen[k]), 32'(err_exp));
    end
    finishRun();
  end

endmodule
